// File: rtl/enc1_pkg.sv
// Shared widths, LFSR taps and the whitening-mask helper for the encrypt_function_1_pipe slice.
package enc1_pkg;

  localparam int PLAIN_W = 60;
  localparam int RAND_W  = 11;
  localparam int TAG_W   = 6;
  localparam int FRAME_W = 78;
  localparam int Y_W     = 61;

  localparam int LFSR_TAP_A = 10;
  localparam int LFSR_TAP_B = 8;

  // Alternating true/inverted copies of r spread across the 60-bit mask.
  function automatic logic [PLAIN_W-1:0] enc1_mask(input logic [RAND_W-1:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  function automatic logic [RAND_W-1:0] enc1_lfsr_next(input logic [RAND_W-1:0] r);
    return {r[RAND_W-2:0], r[LFSR_TAP_A] ^ r[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/enc1_lfsr.sv
// 11-bit Fibonacci LFSR that steps only when the owner accepts a word.
module enc1_lfsr
  import enc1_pkg::*;
#(
  parameter logic [RAND_W-1:0] SEED = 11'h001
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              advance,
  output logic [RAND_W-1:0] value
);

  // The all-zero state would lock the register, so it is remapped.
  localparam logic [RAND_W-1:0] L_SEED = (SEED == 11'h000) ? 11'h001 : SEED;

  logic [RAND_W-1:0] r_state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= L_SEED;
    end else if (advance) begin
      r_state <= enc1_lfsr_next(r_state);
    end
  end

  assign value = r_state;

endmodule

// File: rtl/encrypt_function_1_pipe.sv
// Two-stage whitening encryptor: frame = {plain*2 + mask(r), r, tag}.
// Optional output self-check is enabled by defining ENC1_SELFCHECK_EN.
module encrypt_function_1_pipe
  import enc1_pkg::*;
#(
  parameter logic [RAND_W-1:0] SEED = 11'h001
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PLAIN_W-1:0] plain,
  input  logic [TAG_W-1:0]   tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] outEnc
`ifdef ENC1_SELFCHECK_EN
  ,
  output logic               chk_err
`endif
);

  logic               w_s2_load;
  logic               w_s1_load;
  logic               w_accept;
  logic [RAND_W-1:0]  w_rand;
  logic [Y_W-1:0]     w_y;

  logic               r_s1_valid;
  logic [PLAIN_W-1:0] r_s1_plain;
  logic [TAG_W-1:0]   r_s1_tag;
  logic [RAND_W-1:0]  r_s1_rand;
  logic               r_s2_valid;
  logic [FRAME_W-1:0] r_out_enc;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && w_s1_load;
  assign in_ready  = w_s1_load;

  enc1_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .advance (w_accept),
    .value   (w_rand)
  );

  // Carry out of bit 60 is dropped so that (y - b)[60:1] recovers plain.
  assign w_y = {r_s1_plain, 1'b0} + {1'b0, enc1_mask(r_s1_rand)};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_plain <= '0;
      r_s1_tag   <= '0;
      r_s1_rand  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_plain <= plain;
        r_s1_tag   <= tag;
        r_s1_rand  <= w_rand;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_enc  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_enc <= {w_y, r_s1_rand, r_s1_tag};
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign outEnc    = r_out_enc;

`ifdef ENC1_SELFCHECK_EN
  logic [PLAIN_W-1:0] r_s2_plain;
  logic               r_chk_err;
  logic [PLAIN_W-1:0] w_chk_b;
  logic [PLAIN_W-1:0] w_y_hi;
  logic               w_borrow;
  logic [PLAIN_W-1:0] w_dec_plain;

  // Bits [60:1] of (y - {0,b}) taken directly, borrowing from bit 0.
  assign w_chk_b     = enc1_mask(r_out_enc[RAND_W+TAG_W-1:TAG_W]);
  assign w_y_hi      = r_out_enc[FRAME_W-1:RAND_W+TAG_W+1];
  assign w_borrow    = !r_out_enc[RAND_W+TAG_W] && w_chk_b[0];
  assign w_dec_plain = w_y_hi - {1'b0, w_chk_b[PLAIN_W-1:1]}
                       - {{(PLAIN_W-1){1'b0}}, w_borrow};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s2_plain <= '0;
      r_chk_err  <= 1'b0;
    end else begin
      if (w_s2_load && r_s1_valid) begin
        r_s2_plain <= r_s1_plain;
      end
      if (r_s2_valid && (w_dec_plain != r_s2_plain)) begin
        r_chk_err <= 1'b1;
      end
    end
  end

  assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_encrypt_function_1_pipe.sv
// Directed bench for encrypt_function_1_pipe with a queue-based frame model.
module tb_encrypt_function_1_pipe;
  import enc1_pkg::*;

  logic               Clk = 1'b0;
  logic               Rst_n;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [PLAIN_W-1:0] plain;
  logic [TAG_W-1:0]   tag;
  logic [FRAME_W-1:0] outEnc;
  logic               in_valid2, in_ready2, out_valid2, out_ready2;
  logic [PLAIN_W-1:0] plain2;
  logic [TAG_W-1:0]   tag2;
  logic [FRAME_W-1:0] outEnc2;
`ifdef ENC1_SELFCHECK_EN
  logic               chk_err, chk_err2;
`endif

  always #5 Clk = ~Clk;

  encrypt_function_1_pipe #(.SEED(11'h001)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plain(plain), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .outEnc(outEnc)
`ifdef ENC1_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );

  encrypt_function_1_pipe #(.SEED(11'h7FF)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .plain(plain2), .tag(tag2), .out_valid(out_valid2), .out_ready(out_ready2),
    .outEnc(outEnc2)
`ifdef ENC1_SELFCHECK_EN
    , .chk_err(chk_err2)
`endif
  );

  int                 checks = 0;
  int                 failures = 0;
  int                 pops = 0;
  bit                 skip_cmp = 1'b0;
  logic [FRAME_W-1:0] exp_q[$];
  logic [RAND_W-1:0]  cap_r[$];
  logic [RAND_W-1:0]  r_model;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FRAME_W-1:0] model_frame(input logic [PLAIN_W-1:0] p,
                                                     input logic [TAG_W-1:0] t,
                                                     input logic [RAND_W-1:0] r);
    logic [Y_W-1:0] y;
    y = Y_W'({p, 1'b0}) + Y_W'(enc1_mask(r));
    return {y, r, t};
  endfunction

  function automatic logic [RAND_W-1:0] model_next(input logic [RAND_W-1:0] r);
    return ((r << 1) & 11'h7FF) | (((r >> 10) ^ (r >> 8)) & 11'h001);
  endfunction

  // Scoreboard: every cycle with out_valid the head of the queue must be on outEnc.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
      r_model = 11'h001;
    end else begin
      if (out_valid && !skip_cmp) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%0h required=none", outEnc);
        end else begin
          chk("frame", 80'(outEnc), 80'(exp_q[0]));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        cap_r.push_back(outEnc[16:6]);
        pops++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_frame(plain, tag, r_model));
        r_model = model_next(r_model);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [PLAIN_W-1:0] p, input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid = 1'b1; plain = p; tag = t;
    @(negedge Clk);
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  logic [Y_W-1:0]     y_seed, y_wrap, dec;
  logic [FRAME_W-1:0] hold;
  logic [RAND_W-1:0]  lfsr_tbl[10];
  int                 acc, k, p0, n;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lfsr_tbl = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                 11'h020, 11'h040, 11'h080, 11'h100, 11'h201};
    // mask(001) = {01, 7FE, 001, 7FE, 7FE, 001}; mask(7FF) = {1F, 000, 7FF, 000, 000, 7FF}
    y_seed = (61'h01 << 55) | (61'h7FE << 44) | (61'h001 << 33) |
             (61'h7FE << 22) | (61'h7FE << 11) | 61'h001;
    y_wrap = (61'h1F << 55) | (61'h7FF << 33) | 61'h7FD;

    Rst_n = 1'b1; in_valid = 1'b0; plain = '0; tag = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; plain2 = '0; tag2 = '0; out_ready2 = 1'b1;
    #2 Rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
    chk("rst_outEnc", 80'(outEnc), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1'b1));
`ifdef ENC1_SELFCHECK_EN
    chk("rst_chk_err", 80'(chk_err), 80'(1'b0));
`endif
    Rst_n = 1'b1;

    // Seed frame: latency and literal contents
    send(60'h0, 6'h00);
    chk("lat_early", 80'(out_valid), 80'(1'b0));
    tick();
    chk("lat_valid", 80'(out_valid), 80'(1'b1));
    chk("seed_frame", 80'(outEnc), 80'({y_seed, 11'h001, 6'h00}));

    // Back-to-back stream from a fresh seed
    do_reset();
    cap_r.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; plain = 60'(i) * 60'h123_4567_89AB; tag = 6'(i);
      @(negedge Clk);
      chk("stream_in_ready", 80'(in_ready), 80'(1'b1));
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_count", 80'(cap_r.size()), 80'(10));
    for (int i = 0; i < 10 && i < cap_r.size(); i++)
      chk("lfsr_seq", 80'(cap_r[i]), 80'(lfsr_tbl[i]));

    // Wrap-around on the 7FF-seeded instance
    in_valid2 = 1'b1; plain2 = 60'hFFF_FFFF_FFFF_FFFF; tag2 = 6'h3F;
    @(negedge Clk);
    chk("wrap_in_ready", 80'(in_ready2), 80'(1'b1));
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("wrap_valid", 80'(out_valid2), 80'(1'b1));
    chk("wrap_frame", 80'(outEnc2), 80'({y_wrap, 11'h7FF, 6'h3F}));
    chk("wrap_tag", 80'(outEnc2[5:0]), 80'(6'h3F));
    dec = outEnc2[77:17] - {1'b0, enc1_mask(outEnc2[16:6])};
    chk("wrap_decrypt", 80'(dec[60:1]), 80'(60'hFFF_FFFF_FFFF_FFFF));

    // Backpressure: 3 words offered, 5 cycles with out_ready low
    do_reset();
    cap_r.delete();
    out_ready = 1'b0; acc = 0; k = 0; p0 = pops; hold = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; plain = 60'hABC_0000_0000_0000 + 60'(k); tag = 6'(k + 1);
      @(negedge Clk);
      if (in_ready) begin acc++; k++; end
      if (c == 2) hold = outEnc;
      if (c == 4) chk("bp_hold", 80'(outEnc), 80'(hold));
      tick();
    end
    chk("bp_accepted", 80'(acc), 80'(2));
    chk("bp_in_ready", 80'(in_ready), 80'(1'b0));
    chk("bp_out_valid", 80'(out_valid), 80'(1'b1));
    out_ready = 1'b1;
    send(60'hABC_0000_0000_0000 + 60'(k), 6'(k + 1));
    repeat (4) tick();
    chk("bp_pops", 80'(pops - p0), 80'(3));
    chk("bp_drained", 80'(exp_q.size()), 80'(0));
    if (cap_r.size() == 3) chk("bp_third_r", 80'(cap_r[2]), 80'(11'h004));
    else chk("bp_cap", 80'(cap_r.size()), 80'(3));

    // Reset with both stages full
    out_ready = 1'b0;
    send(60'h111, 6'h01);
    send(60'h222, 6'h02);
    chk("mid_full", 80'(in_ready), 80'(1'b0));
    Rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 80'(out_valid), 80'(1'b0));
    chk("mid_outEnc", 80'(outEnc), 80'(0));
    tick();
    tick();
    Rst_n = 1'b1; out_ready = 1'b1;
    cap_r.delete();
    send(60'h333, 6'h03);
    repeat (3) tick();
    if (cap_r.size() == 1) chk("mid_seed_r", 80'(cap_r[0]), 80'(11'h001));
    else chk("mid_cap", 80'(cap_r.size()), 80'(1));

`ifdef ENC1_SELFCHECK_EN
    do_reset();
    acc = 0; n = 0;
    while (acc < 1000 && n < 5000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      plain = 60'({$urandom(), $urandom()});
      tag = 6'($urandom());
      @(negedge Clk);
      if (in_valid && in_ready) acc++;
      tick();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("sc_words", 80'(acc >= 1000), 80'(1'b1));
    chk("sc_clean", 80'(chk_err), 80'(1'b0));
    out_ready = 1'b0;
    send(60'h5A5, 6'h15);
    tick();
    skip_cmp = 1'b1;
    hold = dut.r_out_enc;
    force dut.r_out_enc = hold ^ (78'd1 << 40);
    tick();
    release dut.r_out_enc;
    tick();
    chk("sc_flag", 80'(chk_err), 80'(1'b1));
    out_ready = 1'b1;
    repeat (3) tick();
    chk("sc_sticky", 80'(chk_err), 80'(1'b1));
    do_reset();
    skip_cmp = 1'b0;
    chk("sc_cleared", 80'(chk_err), 80'(1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
